// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller.
// Serialises one parallel word per frame as start(0) | data LSB-first |
// optional parity | stop(1), one bit per CLK (baud clock) cycle. A word
// offered while the stop bit is on the line is accepted immediately, so
// consecutive frames run with no idle cycle between them.
module uart_tx_frame_ctrl #(
    parameter int P_DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [P_DATA_WIDTH-1:0] P_DATA,
    input  logic                    Data_Valid,
    input  logic                    PAR_EN,
    input  logic                    PAR_BIT,
    output logic                    TX_OUT,
    output logic                    Busy
);

    localparam int CNT_W = $clog2(P_DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(P_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [P_DATA_WIDTH-1:0] data_q;
    logic                    par_en_q;
    logic                    tx_q;
    logic                    busy_q;

    // Index of the data bit that goes on the line after the current one.
    logic [CNT_W-1:0]        nxt_idx;
    assign nxt_idx = bit_cnt_q + 1'b1;

    // Frame sequencer: state, shadow registers and registered line outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Data_Valid) begin
                        data_q   <= P_DATA;
                        par_en_q <= PAR_EN;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end else begin
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    tx_q      <= data_q[0];
                    bit_cnt_q <= '0;
                    state_q   <= DATA;
                end
                DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        // Parity stage output has long settled by now.
                        if (par_en_q) begin
                            tx_q    <= PAR_BIT;
                            state_q <= PARITY;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end
                    end else begin
                        bit_cnt_q <= nxt_idx;
                        tx_q      <= data_q[nxt_idx];
                    end
                end
                PARITY: begin
                    tx_q    <= 1'b1;
                    state_q <= STOP;
                end
                STOP: begin
                    // Back-to-back accept: next start bit follows the stop bit.
                    if (Data_Valid) begin
                        data_q   <= P_DATA;
                        par_en_q <= PAR_EN;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end else begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed testbench for uart_tx_frame_ctrl with a parity-stage model that
// shares the P_DATA/Data_Valid stream. Expected line sequences are written
// out by hand, first bit transmitted leftmost.
module tb_uart_tx_frame_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_BIT;
    logic       TX_OUT;
    logic       Busy;
    logic       par_typ;   // 0 = even, 1 = odd

    int n_cmp;
    int n_bad;

    uart_tx_frame_ctrl #(.P_DATA_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_BIT   (PAR_BIT),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Parity stage model: registers parity of the offered word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            PAR_BIT <= 1'b0;
        else if (Data_Valid)
            PAR_BIT <= (^P_DATA) ^ par_typ;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Offer one word: accepted at the next rising edge, strobe dropped after it.
    task automatic offer(input logic [7:0] d, input logic pe);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pe;
        Data_Valid = 1'b1;
        @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
    endtask

    task automatic test_reset;
        RST        = 1'b0;
        Data_Valid = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        par_typ    = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (TX_OUT !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_tx: TX_OUT got %b want 1", TX_OUT);
        end
        n_cmp++;
        if (Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: Busy got %b want 0", Busy);
        end
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_after_reset cyc=%0d: TX_OUT/Busy got %b%b want 10", i, TX_OUT, Busy);
            end
        end
    endtask

    task automatic test_parity_even;
        logic [0:10] exp;
        exp     = 11'b01010010101;   // 0xA5, even parity 0
        par_typ = 1'b0;
        offer(8'hA5, 1'b1);
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
                n_bad++;
                $display("FAIL even_A5 cyc=%0d: TX_OUT/Busy got %b%b want %b1", i, TX_OUT, Busy, exp[i]);
            end
        end
        @(negedge CLK);
        n_cmp++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL even_A5_end: TX_OUT/Busy got %b%b want 10", TX_OUT, Busy);
        end
    endtask

    task automatic test_parity_odd_and_none;
        logic [0:10] exp_odd;
        logic [0:9]  exp_np;
        exp_odd = 11'b01010010111;   // 0xA5, odd parity 1
        exp_np  = 10'b0001111001;    // 0x3C, no parity
        par_typ = 1'b1;
        offer(8'hA5, 1'b1);
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_OUT !== exp_odd[i] || Busy !== 1'b1) begin
                n_bad++;
                $display("FAIL odd_A5 cyc=%0d: TX_OUT/Busy got %b%b want %b1", i, TX_OUT, Busy, exp_odd[i]);
            end
        end
        @(negedge CLK);
        par_typ = 1'b0;
        offer(8'h3C, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            // Raising PAR_EN mid-frame must not add a parity slot.
            if (i == 2) PAR_EN = 1'b1;
            n_cmp++;
            if (TX_OUT !== exp_np[i] || Busy !== 1'b1) begin
                n_bad++;
                $display("FAIL nopar_3C cyc=%0d: TX_OUT/Busy got %b%b want %b1", i, TX_OUT, Busy, exp_np[i]);
            end
        end
        @(negedge CLK);
        PAR_EN = 1'b0;
        n_cmp++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL nopar_3C_end: TX_OUT/Busy got %b%b want 10", TX_OUT, Busy);
        end
    endtask

    task automatic test_ignore_mid_frame;
        logic [0:10] exp;
        exp     = 11'b01010010101;
        par_typ = 1'b0;
        offer(8'hA5, 1'b1);
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
                n_bad++;
                $display("FAIL ignore_A5 cyc=%0d: TX_OUT/Busy got %b%b want %b1", i, TX_OUT, Busy, exp[i]);
            end
            if (i == 3) begin
                P_DATA     = 8'h81;
                Data_Valid = 1'b1;
            end
            if (i == 6) Data_Valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_bad++;
                $display("FAIL ignore_idle cyc=%0d: TX_OUT/Busy got %b%b want 10", i, TX_OUT, Busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [0:10] f1;
        logic [0:10] f2;
        logic [0:21] exp;
        f1      = 11'b01010101011;   // 0x55, odd parity 1
        f2      = 11'b00101010111;   // 0xAA, odd parity 1
        exp     = {f1, f2};
        par_typ = 1'b1;
        offer(8'h55, 1'b1);
        for (int i = 0; i < 22; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b cyc=%0d: TX_OUT/Busy got %b%b want %b1", i, TX_OUT, Busy, exp[i]);
            end
            if (i == 10) begin
                P_DATA     = 8'hAA;
                Data_Valid = 1'b1;
            end
            if (i == 11) Data_Valid = 1'b0;
        end
        @(negedge CLK);
        n_cmp++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: TX_OUT/Busy got %b%b want 10", TX_OUT, Busy);
        end
    endtask

    task automatic test_async_reset;
        logic [0:10] exp_a5;
        logic [0:10] exp_3c;
        exp_a5  = 11'b01010010101;
        exp_3c  = 11'b00011110011;   // 0x3C, odd parity 1
        par_typ = 1'b0;
        offer(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_OUT !== exp_a5[i]) begin
                n_bad++;
                $display("FAIL rst_pre cyc=%0d: TX_OUT got %b want %b", i, TX_OUT, exp_a5[i]);
            end
        end
        // Data bit 3 is now on the line; reset lands between clock edges.
        @(negedge CLK);
        RST = 1'b0;
        #1;
        n_cmp++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: TX_OUT/Busy got %b%b want 10", TX_OUT, Busy);
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_idle cyc=%0d: TX_OUT/Busy got %b%b want 10", i, TX_OUT, Busy);
            end
        end
        par_typ = 1'b1;
        offer(8'h3C, 1'b1);
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (TX_OUT !== exp_3c[i] || Busy !== 1'b1) begin
                n_bad++;
                $display("FAIL rst_after cyc=%0d: TX_OUT/Busy got %b%b want %b1", i, TX_OUT, Busy, exp_3c[i]);
            end
        end
        @(negedge CLK);
        n_cmp++;
        if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_after_end: TX_OUT/Busy got %b%b want 10", TX_OUT, Busy);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_parity_even();
        test_parity_odd_and_none();
        test_ignore_mid_frame();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
